// File: rtl/alu_seq.sv
// Registered ALU with logic, add/sub, variable shifts and a shift-add multiplier.
// Latency: 1 cycle for non-MUL ops, WIDTH+2 for MUL; a result is held while out_ready is low.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int SHW = $clog2(WIDTH);
    localparam int W2  = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, FINISH, DONE} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [W2-1:0]    mcand;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic             is_signed;

    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   bb;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl_t;
    logic [WIDTH:0]     shr_t;
    logic signed [WIDTH:0] sx;
    logic [WIDTH-1:0]   c_res;
    logic               c_c;
    logic               c_v;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [W2-1:0]      prod;

    assign in_ready = (state == IDLE) && !reset;

    // Single-cycle datapath for every function except MUL.
    always_comb begin
        sh    = b[SHW-1:0];
        bb    = op[3] ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, op[3]};
        shl_t = {1'b0, a} << sh;
        sx    = {a, 1'b0};
        // The extra low bit catches the last bit shifted out.
        if (op[3])
            shr_t = $unsigned(sx >>> sh);
        else
            shr_t = {a, 1'b0} >> sh;
        c_res = '0;
        c_c   = 1'b0;
        c_v   = 1'b0;
        case (op[2:0])
            3'b000: c_res = a & b;
            3'b010: c_res = a | b;
            3'b011: c_res = a ^ b;
            3'b100, 3'b101: begin
                c_res = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                c_v   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                c_res = shl_t[WIDTH-1:0];
                c_c   = shl_t[WIDTH];
            end
            3'b110: begin
                c_res = shr_t[WIDTH:1];
                c_c   = shr_t[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        a_mag = (op[3] && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag = (op[3] && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        prod  = neg ? (~acc + W2'(1)) : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            is_signed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op[2:0] == 3'b111) begin
                            mcand     <= {{WIDTH{1'b0}}, a_mag};
                            mplier    <= b_mag;
                            acc       <= '0;
                            cnt       <= '0;
                            neg       <= op[3] && (a[WIDTH-1] ^ b[WIDTH-1]);
                            is_signed <= op[3];
                            state     <= MUL;
                        end else begin
                            result    <= c_res;
                            result_hi <= '0;
                            flag_c    <= c_c;
                            flag_v    <= c_v;
                            flag_z    <= (c_res == '0);
                            flag_n    <= c_res[WIDTH-1];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    result    <= prod[WIDTH-1:0];
                    result_hi <= prod[W2-1:WIDTH];
                    flag_c    <= is_signed ? (prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                           : (prod[W2-1:WIDTH] != '0);
                    flag_v    <= 1'b0;
                    flag_z    <= (prod[WIDTH-1:0] == '0);
                    flag_n    <= prod[WIDTH-1];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU datapath.
- Keeps the existing 4-bit opcode encoding and adds:
  - WIDTH generalisation;
  - variable shift amounts, including arithmetic right shift;
  - full-width signed/unsigned multiply as a multi-cycle shift-add sequencer;
  - status flags;
  - valid/ready handshakes on input and output.
- Sits between the register-file read stage and write-back.

Parameters:
- WIDTH, 16: operand and result width. Must be a power of two, at least 4.
- SHW (localparam), clog2(WIDTH): width of the shift-amount field taken from b.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation; equals (state==IDLE) && !reset.
- op  input  4  op[3] = modifier bit, op[2:0] = function.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B, or shift amount in b[SHW-1:0].
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  result, or low half of the product.
- result_hi  output  WIDTH  high half of the product; 0 for non-MUL ops.
- flag_c  output  1  carry.
- flag_z  output  1  zero: result==0, low word only.
- flag_n  output  1  negative: result[WIDTH-1].
- flag_v  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid, result, result_hi and all flags = 0. Reset wins over any other event in the same cycle.
- Reset mid-operation: any in-flight MUL or held result is discarded. in_ready is 1 on the first cycle after reset deasserts.
- Operand capture: an operation is accepted on the edge where in_valid && in_ready. op, a and b are captured at that edge and need not be held afterwards.
- Function encoding (op[2:0]):
  - 000 AND, 010 OR, 011 XOR: flag_c = flag_v = 0.
  - 100 / 101 ADD (101 = immediate form, same datapath): op[3]=0 gives a+b; op[3]=1 gives a+~b+1.
    - flag_c = carry out; for SUB, flag_c=1 means no borrow.
    - flag_v = signed overflow.
  - 001 SHL by b[SHW-1:0].
  - 110 SHR by b[SHW-1:0]: op[3]=0 is logical, op[3]=1 is arithmetic (sign fill).
    - Shift amount 0 returns a with flag_c=0.
  - Shift flags: flag_c = last bit shifted out; flag_v = 0.
  - 111 MUL: WIDTH x WIDTH to 2*WIDTH product in {result_hi, result}. op[3]=0 unsigned, op[3]=1 signed two's complement.
    - Signed form: operands converted to magnitudes, product negated at finish if signs differ.
    - flag_c = 1 if the high half is not a pure extension of the low half: unsigned, result_hi != 0; signed, result_hi != {WIDTH{result[WIDTH-1]}}.
    - flag_v = 0.
- State machine:
  - IDLE: on accept, non-MUL ops compute and register outputs, then go to DONE. MUL loads the multiplicand, multiplier and an accumulator of 0, clears the counter, and goes to MUL.
  - MUL: one shift-add step per clock for WIDTH clocks (counter 0..WIDTH-1). Then one FINISH cycle applies sign correction and flags and goes to DONE.
  - DONE: out_valid=1, with result, result_hi and flags held stable. When out_ready=1 at an edge: out_valid is 0 after that edge and the FSM returns to IDLE.
- Latency:
  - Non-MUL: out_valid high after the edge following the accept edge (1 cycle).
  - MUL: WIDTH+2 cycles after accept.
- Throughput: one operation in flight. in_ready=0 in MUL, FINISH and DONE.
  - No accept can occur in the same cycle as output retirement.
  - Next accept is possible 1 cycle after retirement.
- Output stability: while out_valid=1 && out_ready=0, all outputs are held indefinitely.
- Arithmetic: all results are truncated to WIDTH bits, no saturation. The carry chain is WIDTH+1 bits.

Test Plan (WIDTH=16):
1. ADD op=0100, a=0x7FFF, b=0x0001 -> result=0x8000, n=1, v=1, c=0, z=0; out_valid one cycle after accept. SUB op=1100, a=5, b=7 -> 0xFFFE, c=0, n=1, v=0.
2. SHL op=0001, a=0x8001, b=1 -> 0x0002, c=1. SHR arith op=1110, a=0x8010, b=4 -> 0xF801, c=0. SHR logical op=0110, same a and b -> 0x0801. Shift by 0 -> a unchanged, c=0.
3. MUL op=0111, a=0xFFFF, b=0xFFFF -> result_hi=0xFFFE, result=0x0001, c=1; out_valid exactly 18 cycles after accept; in_ready=0 throughout. Signed op=1111, a=0xFFFD (-3), b=0x0005 -> hi=0xFFFF, lo=0xFFF1, c=0, n=1.
4. Backpressure: XOR a=0xF0F0, b=0xFF00 with out_ready=0 for 3 cycles -> result=0x0FF0 stable, out_valid=1, in_ready=0; out_ready=1 -> out_valid drops next cycle, in_ready=1.
5. Reset during MUL at step 5 -> next cycle state IDLE, out_valid=0, all outputs 0, in_ready=1. A following AND a=0x00FF, b=0x0F0F -> 0x000F.
6. Logic flags: AND a=0xAAAA, b=0x5555 -> result=0, z=1, c=0, v=0. in_valid held low -> out_valid never rises.
